// File: rtl/writeback_stage.sv
// Writeback stage: MEM-WB pipeline register, load alignment/extension and the
// register-file write port, with a load-wait FSM that stalls upstream until data returns.

package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [5:0] {
        UNKNOWN,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA
    } alu_ctrl_e;
endpackage

module writeback_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     LD_TIMEOUT = 16,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            validW_i,
    input  logic [XLEN-1:0] pcW_i,
    input  logic [XLEN-1:0] instrW_i,
    input  alu_ctrl_e       operationW_i,
    input  logic [XLEN-1:0] resultW_i,
    input  logic [4:0]      rdW_addr_i,
    input  logic            rdW_wr_ena_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stallW_o,
    output logic [XLEN-1:0] rdD_data_o,
    output logic [4:0]      rdD_addr_o,
    output logic            rdD_wr_ena_o,
    output logic            tb_update_o,
    output logic [XLEN-1:0] pcW_o,
    output logic [XLEN-1:0] instrW_o,
    output logic            ld_err_o
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] WAIT_LD = 1'b1;

    localparam int unsigned      CNT_W    = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LD_TIMEOUT - 1);

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    alu_ctrl_e        ld_op;
    logic [1:0]       ld_off;
    logic [4:0]       ld_rd;
    logic             ld_ena;
    logic [XLEN-1:0]  ld_pc;
    logic [XLEN-1:0]  ld_instr;

    logic is_load;
    logic misaligned;

    assign is_load    = operationW_i inside {LB, LH, LW, LBU, LHU};
    assign misaligned = ((operationW_i == LH || operationW_i == LHU) && resultW_i[0])
                     || (operationW_i == LW && resultW_i[1:0] != 2'b00);

    // Stall depends on the state register alone so no input-to-stall path exists.
    assign stallW_o = (state == WAIT_LD);

    function automatic logic [XLEN-1:0] extract_load(
        input alu_ctrl_e       op,
        input logic [1:0]      off,
        input logic [XLEN-1:0] data
    );
        logic [7:0]  lb;
        logic [15:0] lh;
        lb = data[{off, 3'b000} +: 8];
        lh = data[{off[1], 4'b0000} +: 16];
        case (op)
            LB:      return {{(XLEN-8){lb[7]}}, lb};
            LBU:     return {{(XLEN-8){1'b0}}, lb};
            LH:      return {{(XLEN-16){lh[15]}}, lh};
            LHU:     return {{(XLEN-16){1'b0}}, lh};
            default: return data;
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            ld_op        <= UNKNOWN;
            ld_off       <= 2'b00;
            ld_rd        <= 5'd0;
            ld_ena       <= 1'b0;
            ld_pc        <= RESET_PC;
            ld_instr     <= NOP_INSTR;
            rdD_data_o   <= '0;
            rdD_addr_o   <= 5'd0;
            rdD_wr_ena_o <= 1'b0;
            tb_update_o  <= 1'b0;
            ld_err_o     <= 1'b0;
            pcW_o        <= RESET_PC;
            instrW_o     <= NOP_INSTR;
        end else begin
            // NOTE: non-blocking assignments let these pulse defaults be overridden
            // later in the same block without creating ordering hazards between flops.
            rdD_wr_ena_o <= 1'b0;
            tb_update_o  <= 1'b0;
            ld_err_o     <= 1'b0;

            case (state)
                IDLE: begin
                    if (validW_i) begin
                        if (is_load && misaligned) begin
                            ld_err_o    <= 1'b1;
                            tb_update_o <= 1'b1;
                            pcW_o       <= pcW_i;
                            instrW_o    <= instrW_i;
                        end else if (is_load) begin
                            ld_op    <= operationW_i;
                            ld_off   <= resultW_i[1:0];
                            ld_rd    <= rdW_addr_i;
                            ld_ena   <= rdW_wr_ena_i;
                            ld_pc    <= pcW_i;
                            ld_instr <= instrW_i;
                            cnt      <= '0;
                            state    <= WAIT_LD;
                        end else begin
                            tb_update_o <= 1'b1;
                            pcW_o       <= pcW_i;
                            instrW_o    <= instrW_i;
                            if (operationW_i != UNKNOWN) begin
                                rdD_data_o   <= resultW_i;
                                rdD_addr_o   <= rdW_addr_i;
                                rdD_wr_ena_o <= rdW_wr_ena_i && (rdW_addr_i != 5'd0);
                            end
                        end
                    end
                end

                WAIT_LD: begin
                    // A response arriving on the timeout cycle still completes the load.
                    if (dmem_rvalid_i) begin
                        rdD_data_o   <= extract_load(ld_op, ld_off, dmem_rdata_i);
                        rdD_addr_o   <= ld_rd;
                        rdD_wr_ena_o <= ld_ena && (ld_rd != 5'd0);
                        tb_update_o  <= 1'b1;
                        pcW_o        <= ld_pc;
                        instrW_o     <= ld_instr;
                        state        <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        ld_err_o    <= 1'b1;
                        tb_update_o <= 1'b1;
                        pcW_o       <= ld_pc;
                        instrW_o    <= ld_instr;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage: captures MEM-stage results, aligns and extends load data returned by the data memory, and drives the register-file write port back to decode (rd data / address / write enable).
- Owns the MEM-WB pipeline register, a load-wait state machine with a timeout counter, and the retire pulse for the testbench.
- While a load is outstanding it stalls upstream.

Parameters:
- XLEN, 32, datapath width (from riscv_pkg)
- LD_TIMEOUT, 16, max cycles spent in WAIT_LD before abandoning a load (≥1)
- RESET_PC, 32'h8000_0000, reset value of pcW_o

Ports:
- clk_i  in  1  clock, all state on posedge
- rst_i  in  1  asynchronous, active-high reset
- validW_i  in  1  MEM stage presents a retiring instruction (also tb_update)
- pcW_i  in  XLEN  pc of presented instruction
- instrW_i  in  XLEN  instruction word
- operationW_i  in  alu_ctrl_e  operation from decode/execute
- resultW_i  in  XLEN  execute result; for loads, effective address; for JAL/JALR, link value
- rdW_addr_i  in  5  destination register
- rdW_wr_ena_i  in  1  destination write requested
- dmem_rvalid_i  in  1  load data valid (single-cycle pulse)
- dmem_rdata_i  in  XLEN  aligned 32-bit word containing load data
- stallW_o  out  1  upstream must hold its outputs and validW_i
- rdD_data_o  out  XLEN  register-file write data
- rdD_addr_o  out  5  register-file write address
- rdD_wr_ena_o  out  1  register-file write enable (one-cycle pulse)
- tb_update_o  out  1  retire pulse
- pcW_o  out  XLEN  pc of retiring instruction
- instrW_o  out  XLEN  instr of retiring instruction
- ld_err_o  out  1  one-cycle pulse: misaligned load or timeout

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE, timeout counter 0.
  - rdD_data_o=0, rdD_addr_o=0, rdD_wr_ena_o=0, tb_update_o=0, ld_err_o=0.
  - pcW_o=RESET_PC, instrW_o=32'h0000_0013.
  - stallW_o=0.
- stallW_o = (state==WAIT_LD), decoded from state register only; no combinational path from inputs.
- rdD_wr_ena_o, tb_update_o and ld_err_o default to 0 every cycle; each is asserted for exactly one cycle per event.
- IDLE, validW_i=1, non-load operation:
  - Next edge: rdD_data_o=resultW_i, rdD_addr_o=rdW_addr_i.
  - rdD_wr_ena_o = rdW_wr_ena_i && rdW_addr_i!=0.
  - tb_update_o=1, pcW_o/instrW_o updated. Latency 1 cycle.
- IDLE, validW_i=1, load operation (LB/LH/LW/LBU/LHU):
  - Misaligned case (LH/LHU with offset[0]=1, or LW with offset!=0): no wait.
    - Next edge: ld_err_o=1, tb_update_o=1, rdD_wr_ena_o=0.
    - Stay in IDLE.
  - Otherwise: capture op, rd addr, rd_wr_ena, offset=resultW_i[1:0], pc and instr.
    - Clear counter, go to WAIT_LD. No outputs asserted.
- WAIT_LD:
  - dmem_rvalid_i=1 → at that edge:
    - Extract and extend the loaded value (table below).
    - rdD_data_o=extracted value, rdD_addr_o=captured rd.
    - rdD_wr_ena_o=captured ena && rd!=0, tb_update_o=1.
    - Go to IDLE.
  - rvalid=0 → counter increments. When counter reaches LD_TIMEOUT-1 with no rvalid: ld_err_o=1, tb_update_o=1, no write, go to IDLE.
  - rvalid and timeout in the same cycle: rvalid wins (normal write, no error).
  - validW_i is ignored in WAIT_LD (upstream is stalled and holds it); the held instruction is accepted in the first IDLE cycle.
- Load extraction:
  - LB: dmem_rdata_i[8*off+:8], sign-extended.
  - LBU: same byte, zero-extended.
  - LH: dmem_rdata_i[16*off[1]+:16], sign-extended.
  - LHU: same halfword, zero-extended.
  - LW: full word.
- dmem_rvalid_i in IDLE is ignored, including a late response after a timeout. Minimum load latency: rvalid one cycle after acceptance → write 2 cycles after acceptance.
- operationW_i==UNKNOWN with validW_i=1: retire pulse only, no write.
- Reset asserted mid-load: return to IDLE immediately, with no write, no error and no retire.

Test Plan:
- IDLE, ADDI rd=5 result=32'h1234, ena=1 → next cycle rdD_wr_ena_o=1, addr=5, data=32'h1234, tb_update_o=1; stallW_o stays 0.
- ADD with rd=0, ena=1 → rdD_wr_ena_o=0, tb_update_o=1.
- LB at addr 0x...03, rvalid 2 cycles later with rdata=32'h80FF_FF00 → stallW_o=1 for 2 cycles, then write data=32'hFFFF_FF80; LBU same stimulus → 32'h0000_0080.
- LH at offset 2, rdata=32'h8001_0000 → 32'hFFFF_8001; LHU → 32'h0000_8001; LW at offset 1 → ld_err_o=1, no write, no stall.
- LW with no rvalid, LD_TIMEOUT=4 → stallW_o high 4 cycles, ld_err_o pulse, no write; a late rvalid afterwards is ignored.
- Load outstanding, rst_i pulsed → all outputs at reset values asynchronously, stallW_o=0, no retire; a subsequent ADDI completes normally.
